// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler: config FSM states,
// period width and the named periods used by the calculator front end.
package tick_sched_pkg;

    localparam int unsigned P_W          = 20;
    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned PER_1KHZ     = CLK_HZ / 1_000;
    localparam int unsigned PER_DEBOUNCE = CLK_HZ / 100;
    localparam int unsigned PER_BLINK    = 0;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StDone
    } cfg_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: period register, wrapping counter and registered
// tick / square outputs. A load replaces the period and restarts the count.
module tick_channel #(
    parameter int unsigned P_W            = 20,
    parameter int unsigned DEFAULT_PERIOD = 50000
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           load_i,
    input  logic [P_W-1:0] load_val_i,
    input  logic           sync_i,
    output logic           tick_o,
    output logic           sq_o,
    output logic           wrap_o,
    output logic           idle_o
);

    logic [P_W-1:0] period_q, period_d;
    logic [P_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0] half;
    logic           tick_q, tick_d;
    logic           sq_q, sq_d;

    always_comb begin
        idle_o   = (period_q == '0);
        wrap_o   = !idle_o && (cnt_q == period_q - P_W'(1));
        period_d = load_i ? load_val_i : period_q;

        if (sync_i || load_i || wrap_o || idle_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + P_W'(1);
        end

        tick_d = wrap_o && !sync_i;
        // High phase gets the extra cycle for odd periods; zero period gives half = 0.
        half   = period_d - (period_d >> 1);
        sq_d   = (cnt_d < half);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            period_q <= P_W'(DEFAULT_PERIOD);
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick / clock-enable generator with a valid/ready config port.
// Period writes are held pending until the target channel wraps.
module tick_scheduler #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned P_W            = tick_sched_pkg::P_W,
    parameter int unsigned DEFAULT_PERIOD = tick_sched_pkg::PER_1KHZ
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CH_W-1:0] cfg_chan,
    input  logic [P_W-1:0]  cfg_period,
    output logic            cfg_done,
    output logic            cfg_err,
    input  logic            sync_all,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] sq_out
);

    import tick_sched_pkg::*;

    cfg_state_e      state_q, state_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic [P_W-1:0]  period_q, period_d;
    logic            err_q, err_d;
    logic [N_CH-1:0] wrap_vec;
    logic [N_CH-1:0] idle_vec;
    logic [N_CH-1:0] load_vec;
    logic            chan_ok;
    logic            tgt_ready;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        period_d  = period_q;
        err_d     = 1'b0;
        load_vec  = '0;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        chan_ok   = 1'b0;
        tgt_ready = 1'b0;

        // Decode by comparison so an out-of-range index never selects a channel.
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (cfg_chan == CH_W'(i)) begin
                chan_ok = 1'b1;
            end
            if (chan_q == CH_W'(i)) begin
                tgt_ready = tgt_ready | wrap_vec[i] | idle_vec[i];
            end
        end

        unique case (state_q)
            StIdle: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (chan_ok) begin
                        chan_d   = cfg_chan;
                        period_d = cfg_period;
                        state_d  = StPend;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPend: begin
                if (sync_all || tgt_ready) begin
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        load_vec[i] = (chan_q == CH_W'(i));
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                cfg_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q  <= StIdle;
            chan_q   <= '0;
            period_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            period_q <= period_d;
            err_q    <= err_d;
        end
    end

    assign cfg_err = err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_channel #(
            .P_W            (P_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk_i      (CLOCK_50),
            .rst_ni     (resetn),
            .load_i     (load_vec[g]),
            .load_val_i (period_q),
            .sync_i     (sync_all),
            .tick_o     (tick[g]),
            .sq_o       (sq_out[g]),
            .wrap_o     (wrap_vec[g]),
            .idle_o     (idle_vec[g])
        );
    end

endmodule
